// File: rtl/line_buffer_13x13_pkg.sv
// Shared constants, FSM encoding and tap-rotation helper for line_buffer_13x13.
package line_buffer_13x13_pkg;

  localparam int WIN_SIZE = 13;
  localparam int LB_ROWS  = WIN_SIZE - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    STREAM    = 2'd2,
    FRAME_END = 2'd3
  } lb_state_t;

  // Memory holding row r-12+k, given that the current row is written into memory 'base'.
  function automatic logic [3:0] tap_index(input int k, input logic [3:0] base);
    int sum;
    sum = k + int'({28'd0, base});
    if (sum >= LB_ROWS) sum = sum - LB_ROWS;
    return sum[3:0];
  endfunction

endpackage

// File: rtl/line_buffer_row_ram.sv
// Single-port read-before-write row memory, one image row of pixels.
module line_buffer_row_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read register is reset so the column output is clean straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/line_buffer_13x13.sv
// Raster line buffer emitting 13-pixel vertical columns from 12 stored rows plus the live pixel.
// Optional status ports (o_row_cnt, o_overrun) are enabled with LINE_BUFFER_13X13_STATUS_EN.
module line_buffer_13x13
  import line_buffer_13x13_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_sof,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic [WIN_SIZE*DATA_WIDTH-1:0] o_col,
  output logic                           o_valid,
  output logic                           done_o,
  output logic                           frame_done
`ifdef LINE_BUFFER_13X13_STATUS_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0]  o_row_cnt,
  output logic                           o_overrun
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] FILL_LAST = RW'(LB_ROWS - 1);
  localparam logic [3:0]    WR_LAST   = 4'(LB_ROWS - 1);

  lb_state_t state_q, state_d;

  logic [CW-1:0] col_ptr;
  logic [RW-1:0] row_cnt;
  logic [3:0]    wr_row;

  logic accept, restart, emit, frame_last;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row_cnt;
  logic [3:0]    eff_wr_row;

  logic                  first_pending;
  logic [DATA_WIDTH-1:0] top_q;
  logic [3:0]            base_q;
  logic [DATA_WIDTH-1:0] rd_data [LB_ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    restart    = 1'b0;
    emit       = 1'b0;
    frame_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid && i_sof) begin
          accept  = 1'b1;
          restart = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (i_valid) begin
          accept = 1'b1;
          if (i_sof) restart = 1'b1;
          else if (row_cnt == FILL_LAST && col_ptr == COL_LAST) state_d = STREAM;
        end
      end
      STREAM: begin
        if (i_valid) begin
          accept = 1'b1;
          if (i_sof) begin
            restart = 1'b1;
            state_d = FILL;
          end else begin
            emit = 1'b1;
            if (row_cnt == ROW_LAST && col_ptr == COL_LAST) begin
              frame_last = 1'b1;
              state_d    = FRAME_END;
            end
          end
        end
      end
      FRAME_END: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A restarting pixel is treated as (0,0) regardless of where the old frame stood.
  assign eff_col     = restart ? '0 : col_ptr;
  assign eff_row_cnt = restart ? '0 : row_cnt;
  assign eff_wr_row  = restart ? '0 : wr_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_ptr <= '0;
      row_cnt <= '0;
      wr_row  <= '0;
    end else if (state_q == FRAME_END) begin
      col_ptr <= '0;
      row_cnt <= '0;
      wr_row  <= '0;
    end else if (accept) begin
      if (eff_col == COL_LAST) begin
        col_ptr <= '0;
        row_cnt <= eff_row_cnt + 1'b1;
        wr_row  <= (eff_wr_row == WR_LAST) ? 4'd0 : eff_wr_row + 4'd1;
      end else begin
        col_ptr <= eff_col + 1'b1;
        row_cnt <= eff_row_cnt;
        wr_row  <= eff_wr_row;
      end
    end
  end

  for (genvar g = 0; g < LB_ROWS; g++) begin : g_row
    line_buffer_row_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_WIDTH)
    ) u_ram (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (accept),
      .we   (eff_wr_row == 4'(g)),
      .addr (eff_col),
      .wdata(i_data),
      .rdata(rd_data[g])
    );
  end

  // base_q remembers which memory took the write, so rotation matches the read data even after wr_row advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid       <= 1'b0;
      done_o        <= 1'b0;
      frame_done    <= 1'b0;
      first_pending <= 1'b0;
      top_q         <= '0;
      base_q        <= '0;
    end else begin
      o_valid    <= emit;
      done_o     <= emit && first_pending;
      frame_done <= frame_last;
      if (restart)   first_pending <= 1'b1;
      else if (emit) first_pending <= 1'b0;
      if (accept) begin
        top_q  <= i_data;
        base_q <= eff_wr_row;
      end
    end
  end

  always_comb begin
    o_col = '0;
    for (int k = 0; k < LB_ROWS; k++) begin
      o_col[k*DATA_WIDTH +: DATA_WIDTH] = rd_data[tap_index(k, base_q)];
    end
    o_col[LB_ROWS*DATA_WIDTH +: DATA_WIDTH] = top_q;
  end

`ifdef LINE_BUFFER_13X13_STATUS_EN
  assign o_row_cnt = row_cnt;

  // Sticky: data offered while the buffer cannot take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overrun <= 1'b0;
    end else if (i_valid && (state_q == FRAME_END || (state_q == IDLE && !i_sof))) begin
      o_overrun <= 1'b1;
    end else if (i_sof) begin
      o_overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_line_buffer_13x13.sv
// Randomized self-checking bench for line_buffer_13x13 on a 16x16 image, against a frame-array model.
module tb_line_buffer_13x13;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int DW = 8;

  logic           clk;
  logic           rst_n;
  logic           i_sof;
  logic           i_valid;
  logic [DW-1:0]  i_data;
  logic [13*DW-1:0] o_col;
  logic           o_valid;
  logic           done_o;
  logic           frame_done;
`ifdef LINE_BUFFER_13X13_STATUS_EN
  logic [3:0]     o_row_cnt;
  logic           o_overrun;
`endif

  int total;
  int bad;

  line_buffer_13x13 #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sof     (i_sof),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_col     (o_col),
    .o_valid   (o_valid),
    .done_o    (done_o),
    .frame_done(frame_done)
`ifdef LINE_BUFFER_13X13_STATUS_EN
    ,
    .o_row_cnt (o_row_cnt),
    .o_overrun (o_overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the current frame as a 2-D array, indexed by raster position.
  int            pos;
  bit            active;
  bit            done_issued;
  bit            fe_pending;
  logic [DW-1:0] img [H][W];
  logic          exp_valid;
  logic          exp_done;
  logic          exp_fdone;
  logic [13*DW-1:0] exp_col;

  task automatic model_reset();
    active     = 1'b0;
    fe_pending = 1'b0;
    pos        = 0;
  endtask

  task automatic model_step(input bit sof, input bit valid, input logic [DW-1:0] data);
    int r;
    int c;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_fdone = 1'b0;
    exp_col   = '0;
    if (fe_pending) begin
      fe_pending = 1'b0;
      return;
    end
    if (!valid) return;
    if (sof) begin
      pos         = 0;
      active      = 1'b1;
      done_issued = 1'b0;
    end else if (!active) begin
      return;
    end
    r = pos / W;
    c = pos % W;
    img[r][c] = data;
    if (r >= 12) begin
      exp_valid   = 1'b1;
      exp_done    = !done_issued;
      done_issued = 1'b1;
      for (int k = 0; k < 12; k++) exp_col[k*DW +: DW] = img[r-12+k][c];
      exp_col[12*DW +: DW] = data;
      if (pos == W*H-1) begin
        exp_fdone  = 1'b1;
        fe_pending = 1'b1;
        active     = 1'b0;
      end
    end
    pos++;
  endtask

  task automatic step(input bit sof, input bit valid, input logic [DW-1:0] data);
    @(negedge clk);
    i_sof   = sof;
    i_valid = valid;
    i_data  = data;
    model_step(sof, valid, data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    i_sof   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    model_reset();
    #23;
    total++; if (o_valid !== 1'b0)    begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", o_valid); end
    total++; if (done_o !== 1'b0)     begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done_o); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_fdone got=%b exp=0", frame_done); end
    total++; if (o_col !== '0)        begin bad++; $display("[TB] FAIL reset_col got=%h exp=0", o_col); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    logic [13*DW-1:0] spec_col;
    int dones;
    dones = 0;
    step(0, 0, '0);
    for (int n = 0; n < W*H; n++) begin
      step(n == 0, 1, 8'(n));
      if (done_o === 1'b1) dones++;
      total++; if (o_valid !== exp_valid) begin bad++; $display("[TB] FAIL full_valid n=%0d got=%b exp=%b", n, o_valid, exp_valid); end
      total++; if (done_o !== exp_done)   begin bad++; $display("[TB] FAIL full_done n=%0d got=%b exp=%b", n, done_o, exp_done); end
      total++; if (frame_done !== exp_fdone) begin bad++; $display("[TB] FAIL full_fdone n=%0d got=%b exp=%b", n, frame_done, exp_fdone); end
      if (exp_valid) begin
        total++; if (o_col !== exp_col) begin bad++; $display("[TB] FAIL full_col n=%0d got=%h exp=%h", n, o_col, exp_col); end
      end
      if (n == 192) begin
        for (int k = 0; k < 13; k++) spec_col[k*DW +: DW] = 8'(k*16);
        total++; if (done_o !== 1'b1 || o_col !== spec_col) begin bad++; $display("[TB] FAIL first_col done=%b got=%h exp=%h", done_o, o_col, spec_col); end
      end
      if (n == W*H-1) begin
        for (int k = 0; k < 13; k++) spec_col[k*DW +: DW] = 8'(63 + k*16);
        total++; if (frame_done !== 1'b1 || o_valid !== 1'b1 || o_col !== spec_col) begin bad++; $display("[TB] FAIL last_col fdone=%b valid=%b got=%h exp=%h", frame_done, o_valid, o_col, spec_col); end
      end
    end
    total++; if (dones != 1) begin bad++; $display("[TB] FAIL done_count got=%0d exp=1", dones); end
    // Pixels without i_sof after the frame must be ignored.
    for (int n = 0; n < 4; n++) begin
      step(0, n != 0, 8'h5A);
      total++; if (o_valid !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("[TB] FAIL idle_quiet n=%0d valid=%b fdone=%b exp=0", n, o_valid, frame_done); end
    end
  endtask

  task automatic test_random_gaps();
    bit started;
    bit finished;
    bit v;
    int outs;
    int cycles;
    started  = 1'b0;
    finished = 1'b0;
    outs     = 0;
    cycles   = 0;
    step(0, 0, '0);
    while (!finished && cycles < 2000) begin
      v = 1'($urandom_range(0, 1));
      step(v && !started, v, 8'($urandom));
      if (v) started = 1'b1;
      cycles++;
      if (o_valid === 1'b1) outs++;
      total++; if (o_valid !== exp_valid) begin bad++; $display("[TB] FAIL rand_valid c=%0d got=%b exp=%b", cycles, o_valid, exp_valid); end
      total++; if (done_o !== exp_done || frame_done !== exp_fdone) begin bad++; $display("[TB] FAIL rand_flags c=%0d done=%b/%b fdone=%b/%b", cycles, done_o, exp_done, frame_done, exp_fdone); end
      if (exp_valid) begin
        total++; if (o_col !== exp_col) begin bad++; $display("[TB] FAIL rand_col c=%0d got=%h exp=%h", cycles, o_col, exp_col); end
      end
      if (exp_fdone) finished = 1'b1;
    end
    total++; if (!finished) begin bad++; $display("[TB] FAIL rand_timeout got=%0d cycles exp=frame end", cycles); end
    total++; if (outs != 64) begin bad++; $display("[TB] FAIL rand_count got=%0d exp=64", outs); end
    step(0, 0, '0);
  endtask

  task automatic test_restart();
    int acc;
    bit seen;
    acc  = 0;
    seen = 1'b0;
    for (int n = 0; n < 5*W+3; n++) step(n == 0, 1, 8'($urandom));
    step(1, 1, 8'($urandom));
    acc = 1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL restart_valid got=%b exp=0", o_valid); end
    while (!seen && acc < 400) begin
      step(0, 1, 8'($urandom));
      acc++;
      total++; if (o_valid !== exp_valid || done_o !== exp_done) begin bad++; $display("[TB] FAIL restart_flags acc=%0d valid=%b/%b done=%b/%b", acc, o_valid, exp_valid, done_o, exp_done); end
      if (exp_valid) begin
        total++; if (o_col !== exp_col) begin bad++; $display("[TB] FAIL restart_col acc=%0d got=%h exp=%h", acc, o_col, exp_col); end
      end
      if (done_o === 1'b1) seen = 1'b1;
    end
    total++; if (!seen || acc != 193) begin bad++; $display("[TB] FAIL restart_latency got=%0d seen=%b exp=193", acc, seen); end
  endtask

  task automatic test_reset_mid();
    bit finished;
    for (int n = 0; n <= 13*W+7; n++) step(n == 0, 1, 8'($urandom));
    total++; if (o_valid !== 1'b1) begin bad++; $display("[TB] FAIL premid_valid got=%b exp=1", o_valid); end
    @(negedge clk);
    i_valid = 1'b0;
    i_sof   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0 || done_o !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_flags valid=%b done=%b fdone=%b exp=0", o_valid, done_o, frame_done); end
    total++; if (o_col !== '0) begin bad++; $display("[TB] FAIL mid_reset_col got=%h exp=0", o_col); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    finished = 1'b0;
    for (int n = 0; n < W*H; n++) begin
      step(n == 0, 1, 8'($urandom));
      total++; if (o_valid !== exp_valid || done_o !== exp_done || frame_done !== exp_fdone) begin bad++; $display("[TB] FAIL post_flags n=%0d valid=%b/%b done=%b/%b fdone=%b/%b", n, o_valid, exp_valid, done_o, exp_done, frame_done, exp_fdone); end
      if (exp_valid) begin
        total++; if (o_col !== exp_col) begin bad++; $display("[TB] FAIL post_col n=%0d got=%h exp=%h", n, o_col, exp_col); end
      end
    end
  endtask

`ifdef LINE_BUFFER_13X13_STATUS_EN
  task automatic test_overrun();
    step(0, 1, 8'h11);
    total++; if (o_overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_set got=%b exp=1", o_overrun); end
    step(0, 0, '0);
    total++; if (o_overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_sticky got=%b exp=1", o_overrun); end
    step(1, 0, '0);
    total++; if (o_overrun !== 1'b0) begin bad++; $display("[TB] FAIL overrun_clear got=%b exp=0", o_overrun); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_full_frame();
    test_random_gaps();
    test_restart();
    test_reset_mid();
`ifdef LINE_BUFFER_13X13_STATUS_EN
    test_overrun();
`else
    step(0, 0, '0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
